gzip_axis_out_framer: RTL and testbench
=======================================

// Module: gzip_axis_out_framer
// PURPOSE
// - Downstream of the Deflate core: drains its 32-bit output FIFO (1-cycle read latency) into an AXI4-Stream master.
// - Marks the final compressed word with tlast once the core reports done; feeds the core->m_axis async FIFO.
// - Replaces the ad-hoc rden/tvalid glue with a credit-controlled buffer: 1 word/cycle throughput, exact tlast.
// PARAMETERS
// - BUF_DEPTH   4   internal buffer entries; power of 2, >=4 (must hold 3 entries for full rate with hold-back)
// - DATA_W      32  word width
// - CNT_W       32  word-counter width
// PORTS
// - clk            in   1       core clock; all logic on posedge clk
// - rst_n          in   1       synchronous active-low reset
// - fifo_empty     in   1       core output FIFO empty
// - fifo_rden      out  1       core FIFO read strobe; fifo_data valid the following cycle
// - fifo_data      in   DATA_W  core FIFO read data
// - core_done      in   1       level; core has written its last word to the FIFO (deasserts on core reset)
// - m_tdata        out  DATA_W  stream data
// - m_tvalid       out  1       stream valid
// - m_tready       in   1       stream ready
// - m_tlast        out  1       final word of the compressed stream
// - stream_end     out  1       1-cycle pulse: tlast beat accepted, or zero-length stream closed
// - err_overrun    out  1       sticky: FIFO non-empty while in DONE
// - word_cnt       out  CNT_W   accepted beats this stream (optional, see CONFIGURATION)
// BEHAVIOUR
// - Reset: fifo_rden=0, m_tvalid=0, m_tlast=0, m_tdata=0, stream_end=0, err_overrun=0, word_cnt=0, buffer empty, state IDLE.
// - Credit: fifo_rden = ~fifo_empty & (state!=DONE) & (occ + rden_q - pop < BUF_DEPTH); rden_q = registered fifo_rden;
//   pop = m_tvalid & m_tready. Word written into buffer on cycle after rden (rden_q). Buffer never overflows.
// - Hold-back: head entry presented (m_tvalid=1) only if a successor exists (occ>=2 or rden_q) or state==FLUSH.
// - tlast: m_tlast=1 iff state==FLUSH & occ==1 & ~rden_q & fifo_empty.
// - AXIS: once m_tvalid=1, m_tdata/m_tlast stable until m_tready; m_tvalid never drops without a handshake.
// - FSM:
//   IDLE: occ==0; -> STREAM on first fifo_rden; -> FLUSH on core_done (zero-length path).
//   STREAM: -> FLUSH when core_done sampled high (reads continue to drain FIFO).
//   FLUSH: tlast beat accepted -> DONE, stream_end=1; if occ==0 & ~rden_q & fifo_empty (zero words) -> DONE, stream_end=1, no beat.
//   DONE: no reads; fifo_empty=0 sets err_overrun; core_done low -> IDLE, word_cnt cleared, err_overrun kept until rst_n.
// - Simultaneous: pop and rden_q write same cycle -> occ unchanged; core_done rising same cycle as last rden -> tlast on that word.
// - core_done drop mid-FLUSH: ignored; FLUSH completes. rst_n mid-stream: buffer and in-flight read discarded.
// - Latency: fifo_rden -> m_tvalid >= 2 cycles (read + buffer); steady state 1 beat/cycle with m_tready=1.
// CONFIGURATION
// - GZIP_OUT_WORDCNT_EN defined: word_cnt increments per accepted beat, saturates at all-ones, cleared entering IDLE.
// - Not defined: word_cnt tied to 0, counter logic absent.
// STRUCTURE
// - gzip_pkg: FSM state encodings (IDLE/STREAM/FLUSH/DONE), BUF_DEPTH minimum check constant, DATA_W default.
// - Sub-module gzip_axis_skid_fifo: sync BUF_DEPTH x DATA_W FIFO with occupancy output; framer holds FSM, credit, tlast.
// TESTING
// - 8 words 0x1..0x8 queued, core_done high after last, m_tready=1 -> 8 beats back-to-back, tlast only on 0x8, stream_end once.
// - Same 8 words, m_tready toggling 1010... -> data order intact, tdata stable while stalled, fifo_rden never exceeds credit.
// - core_done high with FIFO empty, no words ever -> no beats, stream_end pulse, state DONE.
// - Single word 0xDEADBEEF, core_done 5 cycles later -> beat held until done, then one beat with tlast=1.
// - In DONE, fifo_empty=0 -> no fifo_rden, err_overrun=1; core_done low -> IDLE, word_cnt=0.
// - rst_n low mid-stream after 3 of 6 beats -> all outputs to reset values next cycle; with GZIP_OUT_WORDCNT_EN word_cnt=3 before reset.

Source files
------------

// File: rtl/gzip_pkg.sv
// gzip_pkg: shared state encoding and constants for the gzip AXIS output framer.
package gzip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } frame_state_t;

  // Three entries are needed for full rate while the head is held back; four is the
  // smallest power of two that covers it.
  localparam int unsigned BUF_DEPTH_MIN  = 4;
  localparam int unsigned DATA_W_DEFAULT = 32;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/gzip_axis_skid_fifo.sv
// gzip_axis_skid_fifo: synchronous DEPTH x DATA_W FIFO with occupancy count.
// Head word is visible combinationally on rd_data whenever occ is non-zero.
module gzip_axis_skid_fifo
  import gzip_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned OCC_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [OCC_W-1:0]  occ
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  count;

  // Storage array; contents are only observed behind a non-zero occupancy.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Read/write pointers and occupancy; simultaneous push and pop leave occ unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign occ     = count;

endmodule

// File: rtl/gzip_axis_out_framer.sv
// gzip_axis_out_framer: drains the Deflate core output FIFO into an AXI4-Stream master
// with credit-controlled reads, one-word hold-back and an exact tlast on the final word.
// Optional feature macro: GZIP_OUT_WORDCNT_EN enables the accepted-beat counter on word_cnt.
module gzip_axis_out_framer
  import gzip_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rden,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              core_done,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              stream_end,
  output logic              err_overrun,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned SUM_W = OCC_W + 1;

  if (BUF_DEPTH < BUF_DEPTH_MIN || !is_pow2(BUF_DEPTH)) begin : g_bad_depth
    $error("BUF_DEPTH must be a power of 2 and at least %0d", BUF_DEPTH_MIN);
  end

  frame_state_t      state;
  frame_state_t      state_nxt;
  logic              rden_q;
  logic              pop;
  logic              flush;
  logic              zero_len;
  logic [OCC_W-1:0]  occ;
  logic [SUM_W-1:0]  credit_occ;
  logic [DATA_W-1:0] head;

  gzip_axis_skid_fifo #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rden_q),
    .wr_data (fifo_data),
    .rd_en   (pop),
    .rd_data (head),
    .occ     (occ)
  );

  // Hold-back: the head is only offered once a successor exists or the stream is
  // closing, so the final word can always be tagged with tlast before it leaves.
  assign flush      = (state == ST_FLUSH);
  assign m_tvalid   = (occ != '0) && ((occ >= OCC_W'(2)) || rden_q || flush);
  assign m_tlast    = flush && (occ == OCC_W'(1)) && !rden_q && fifo_empty;
  assign m_tdata    = m_tvalid ? head : '0;
  assign pop        = m_tvalid && m_tready;
  assign zero_len   = (occ == '0) && !rden_q && fifo_empty;

  // Occupancy projected one cycle ahead, counting the in-flight read and this cycle's pop.
  assign credit_occ = SUM_W'(occ) + SUM_W'(rden_q) - SUM_W'(pop);
  assign fifo_rden  = rst_n && !fifo_empty && (state != ST_DONE) &&
                      (credit_occ < SUM_W'(BUF_DEPTH));

  // Read-data-valid flag: core FIFO data lands in the buffer one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) rden_q <= 1'b0;
    else        rden_q <= fifo_rden;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state and end-of-stream pulse.
  always_comb begin
    state_nxt  = state;
    stream_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (core_done)      state_nxt = ST_FLUSH;
        else if (fifo_rden) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (core_done) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if ((pop && m_tlast) || zero_len) begin
          state_nxt  = ST_DONE;
          stream_end = 1'b1;
        end
      end
      ST_DONE: begin
        if (!core_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sticky overrun flag: the core produced data after the stream was closed.
  always_ff @(posedge clk) begin
    if (!rst_n)                                 err_overrun <= 1'b0;
    else if (state == ST_DONE && !fifo_empty)   err_overrun <= 1'b1;
  end

`ifdef GZIP_OUT_WORDCNT_EN
  logic [CNT_W-1:0] cnt;

  // Accepted-beat counter, saturating, cleared on the DONE -> IDLE transition.
  always_ff @(posedge clk) begin
    if (!rst_n)                                cnt <= '0;
    else if (state == ST_DONE && !core_done)   cnt <= '0;
    else if (pop && (cnt != '1))               cnt <= cnt + 1'b1;
  end

  assign word_cnt = cnt;
`else
  assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_gzip_axis_out_framer.sv
// tb_gzip_axis_out_framer: table-driven and randomized streams against a queue-based
// model of the core FIFO and the expected beat sequence.
module tb_gzip_axis_out_framer;

  localparam int unsigned BD = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;
`ifdef GZIP_OUT_WORDCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_rden;
  logic [DW-1:0] fifo_data;
  logic          core_done;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          stream_end;
  logic          err_overrun;
  logic [CW-1:0] word_cnt;

  always #5 clk = ~clk;

  gzip_axis_out_framer #(
    .BUF_DEPTH (BD),
    .DATA_W    (DW),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rden   (fifo_rden),
    .fifo_data   (fifo_data),
    .core_done   (core_done),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .stream_end  (stream_end),
    .err_overrun (err_overrun),
    .word_cnt    (word_cnt)
  );

  typedef struct {
    int unsigned n;
    logic [31:0] base;
    int unsigned gap;
    int unsigned mode;      // 0: ready always, 1: ready 1010..., 2: random ready
    bit          rnd;
    bit          b2b;
    int unsigned exp_beats;
    int unsigned exp_lasts;
  } vec_t;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  int unsigned   reads, beats, lasts, ends;
  int unsigned   ready_mode;
  int            cyc = 0;
  int            first_beat, last_beat;
  bit            done_raised;
  logic          stall_v = 1'b0;
  logic [DW-1:0] stall_d;
  logic          stall_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic refresh();
    fifo_empty = (src_q.size() == 0);
  endtask

  // One clock: observe/check at negedge, then apply the core FIFO and ready effects
  // just after the posedge.
  task automatic cycle();
    logic rd, hs;
    int   inflight;
    @(negedge clk);
    rd = fifo_rden;
    hs = m_tvalid & m_tready;
    if (rst_n) begin
      if (stall_v) begin
        chk("hold_valid", m_tvalid, 1'b1);
        chk("hold_data",  m_tdata,  stall_d);
        chk("hold_last",  m_tlast,  stall_l);
      end
      if (rd) chk("rden_when_empty", fifo_empty, 1'b0);
      if (stream_end) begin
        ends++;
        chk("stream_end_cause",
            (hs && m_tlast) || (!hs && beats == 0 && done_raised && exp_q.size() == 0), 1'b1);
      end
      if (hs) begin
        if (exp_q.size() == 0) fail("beat_with_no_word_pending");
        else begin
          if (exp_q.size() == 1) chk("holdback_final", done_raised, 1'b1);
          chk("tdata", m_tdata, exp_q[0]);
          chk("tlast", m_tlast, (exp_q.size() == 1) && done_raised);
          void'(exp_q.pop_front());
        end
        beats++;
        if (m_tlast) lasts++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
      end
      inflight = int'(reads) + int'(rd) - int'(beats);
      if (rd) chk("credit", inflight <= int'(BD), 1'b1);
      stall_v = m_tvalid & ~m_tready;
      stall_d = m_tdata;
      stall_l = m_tlast;
    end else begin
      stall_v = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rd) begin
      reads++;
      fifo_data = (src_q.size() != 0) ? src_q.pop_front() : 32'hBAD0_BAD0;
    end
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
    refresh();
    cyc++;
  endtask

  // Queue a stream, raise core_done after v.gap cycles and wait for it to close.
  task automatic run_case(input vec_t v);
    logic [DW-1:0] w;
    int unsigned   guard;
    reads = 0; beats = 0; lasts = 0; ends = 0;
    first_beat = -1; last_beat = -1;
    done_raised = 1'b0;
    ready_mode  = v.mode;
    m_tready    = 1'b1;
    for (int unsigned i = 0; i < v.n; i++) begin
      w = v.rnd ? 32'($urandom) : v.base + 32'(i);
      src_q.push_back(w);
      exp_q.push_back(w);
    end
    refresh();
    repeat (v.gap) cycle();
    if (v.n == 1 && v.gap >= 3) chk("single_word_held", m_tvalid, 1'b0);
    core_done   = 1'b1;
    done_raised = 1'b1;
    guard = 0;
    while (ends == 0 && guard < 500) begin
      cycle();
      guard++;
    end
    chk("stream_end_seen", ends, 1);
    repeat (3) cycle();
    chk("stream_end_once", ends, 1);
    chk("beats", beats, v.exp_beats);
    chk("tlast_count", lasts, v.exp_lasts);
    chk("words_left", exp_q.size(), 0);
    if (v.b2b) chk("back_to_back", last_beat - first_beat, v.n - 1);
    chk("word_cnt_done", word_cnt, CNT_EN ? 32'(v.n) : 32'd0);
  endtask

  task automatic close_case();
    core_done   = 1'b0;
    done_raised = 1'b0;
    repeat (2) cycle();
    chk("word_cnt_idle", word_cnt, 0);
  endtask

  initial begin
    vec_t        tbl[5];
    vec_t        v;
    int unsigned guard;

    tbl[0] = '{n: 8, base: 32'h1, gap: 1, mode: 0, rnd: 0, b2b: 1, exp_beats: 8, exp_lasts: 1};
    tbl[1] = '{n: 8, base: 32'h1, gap: 1, mode: 1, rnd: 0, b2b: 0, exp_beats: 8, exp_lasts: 1};
    tbl[2] = '{n: 0, base: 32'h0, gap: 2, mode: 0, rnd: 0, b2b: 0, exp_beats: 0, exp_lasts: 0};
    tbl[3] = '{n: 1, base: 32'hDEADBEEF, gap: 5, mode: 0, rnd: 0, b2b: 0, exp_beats: 1, exp_lasts: 1};
    tbl[4] = '{n: 5, base: 32'hA0, gap: 0, mode: 1, rnd: 0, b2b: 0, exp_beats: 5, exp_lasts: 1};

    rst_n = 1'b0; fifo_empty = 1'b1; fifo_data = '0; core_done = 1'b0; m_tready = 1'b0;
    ready_mode = 0; reads = 0; beats = 0; done_raised = 1'b0;
    repeat (3) cycle();
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tlast", m_tlast, 1'b0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_rden", fifo_rden, 1'b0);
    chk("rst_stream_end", stream_end, 1'b0);
    chk("rst_err", err_overrun, 1'b0);
    chk("rst_word_cnt", word_cnt, 0);
    rst_n = 1'b1;
    cycle();

    for (int unsigned i = 0; i < 5; i++) begin
      run_case(tbl[i]);
      close_case();
    end

    for (int unsigned i = 0; i < 12; i++) begin
      v.n = $urandom_range(0, 20);
      v.base = '0; v.gap = $urandom_range(0, 12); v.mode = 2; v.rnd = 1; v.b2b = 0;
      v.exp_beats = v.n;
      v.exp_lasts = (v.n != 0) ? 1 : 0;
      run_case(v);
      close_case();
    end

    // Core writes after the stream closed: no reads, sticky error.
    v = '{n: 3, base: 32'h100, gap: 1, mode: 0, rnd: 0, b2b: 0, exp_beats: 3, exp_lasts: 1};
    run_case(v);
    src_q.push_back(32'h5555_AAAA);
    refresh();
    cycle();
    chk("done_no_rden", fifo_rden, 1'b0);
    cycle();
    chk("err_overrun_set", err_overrun, 1'b1);
    src_q.delete();
    refresh();
    close_case();
    chk("err_overrun_sticky", err_overrun, 1'b1);

    // Reset in the middle of a stream after three accepted beats.
    reads = 0; beats = 0; lasts = 0; ends = 0; first_beat = -1;
    ready_mode = 0; m_tready = 1'b1; done_raised = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      src_q.push_back(32'h200 + 32'(i));
      exp_q.push_back(32'h200 + 32'(i));
    end
    refresh();
    guard = 0;
    while (beats < 3 && guard < 100) begin
      cycle();
      guard++;
    end
    chk("mid_beats", beats, 3);
    chk("mid_word_cnt", word_cnt, CNT_EN ? 32'd3 : 32'd0);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_tvalid", m_tvalid, 1'b0);
    chk("mid_rst_tlast", m_tlast, 1'b0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_rden", fifo_rden, 1'b0);
    chk("mid_rst_stream_end", stream_end, 1'b0);
    chk("mid_rst_err", err_overrun, 1'b0);
    chk("mid_rst_word_cnt", word_cnt, 0);
    src_q.delete();
    exp_q.delete();
    refresh();
    rst_n = 1'b1;
    cycle();

    v = '{n: 6, base: 32'h300, gap: 2, mode: 2, rnd: 0, b2b: 0, exp_beats: 6, exp_lasts: 1};
    run_case(v);
    close_case();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
